// File: rtl/mem_access_unit.sv
// Memory-stage access controller: one data-cache request per load/store, pipeline stall until
// the cache responds, registered load/SC result, and the LL/SC link register.
module mem_access_unit #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dmemREN_in,
  input  logic              dmemWEN_in,
  input  logic              datomic_in,
  input  logic [WORD_W-1:0] dmemaddr_in,
  input  logic [WORD_W-1:0] dmemstore_in,
  input  logic              halt_in,
  input  logic              flush,
  input  logic              pipe_advance,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [WORD_W-1:0] memload_out,
  output logic              link_valid
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   load_q, load_d;
  logic                link_valid_q, link_valid_d;
  logic [WORD_W-3:0]   link_addr_q, link_addr_d;

  logic is_req, is_store, is_load, is_ll, is_sc, is_sw;
  logic in_access, addr_matches_link, snoop_hit, sc_ok;
  logic ll_set, sc_clear, sw_clear;

  // Link granularity is the word; byte offsets of snooped addresses are irrelevant.
  logic unused_snoop_offset;
  assign unused_snoop_offset = ^snoop_addr[1:0];

  // Both enables set is illegal and resolves to a store.
  assign is_store  = dmemWEN_in;
  assign is_load   = dmemREN_in & ~dmemWEN_in;
  assign is_req    = dmemREN_in | dmemWEN_in;
  assign is_ll     = is_load & datomic_in;
  assign is_sc     = is_store & datomic_in;
  assign is_sw     = is_store & ~datomic_in;
  assign in_access = (state_q == StAccess);

  assign addr_matches_link = (dmemaddr_in[WORD_W-1:2] == link_addr_q);
  assign snoop_hit = snoop_inv & link_valid_q & (snoop_addr[WORD_W-1:2] == link_addr_q);
  // A snoop on the linked word in the same cycle as the check must make the SC fail.
  assign sc_ok     = link_valid_q & addr_matches_link & ~snoop_hit;

  always_comb begin
    state_d      = state_q;
    load_d       = load_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    ll_set       = 1'b0;
    sc_clear     = 1'b0;
    sw_clear     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_req && !flush) begin
          if (is_sc) begin
            sc_clear = 1'b1;
            if (sc_ok) begin
              state_d = StAccess;
              load_d  = {{(WORD_W-1){1'b0}}, 1'b1};
            end else begin
              state_d = StDone;
              load_d  = '0;
            end
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (dhit) begin
          state_d = StDone;
          if (is_load) load_d = dmemload;
          ll_set   = is_ll;
          sc_clear = is_sc;
          sw_clear = is_sw & addr_matches_link;
        end
      end
      StDone: begin
        if (pipe_advance) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (halt_in) begin
      link_valid_d = 1'b0;
    end else if (ll_set) begin
      link_valid_d = 1'b1;
      link_addr_d  = dmemaddr_in[WORD_W-1:2];
    end else if (sc_clear || sw_clear || snoop_hit) begin
      link_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIdle;
      load_q       <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      load_q       <= load_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  // Cache request exists only in ACCESS, so an async reset drops it immediately.
  always_comb begin
    dmemREN     = in_access & is_load;
    dmemWEN     = in_access & is_store;
    dmemaddr    = in_access ? dmemaddr_in : '0;
    dmemstore   = (in_access && is_store) ? dmemstore_in : '0;
    mem_stall   = in_access | ((state_q == StIdle) & is_req & ~flush);
    memload_out = load_q;
    link_valid  = link_valid_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: loads, LL/SC with snoops and stores,
// flush, DONE hold, halt and async reset during ACCESS.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dmemREN_in, dmemWEN_in, datomic_in;
  logic [31:0] dmemaddr_in, dmemstore_in;
  logic        halt_in, flush, pipe_advance, dhit;
  logic [31:0] dmemload;
  logic        snoop_inv;
  logic [31:0] snoop_addr;
  logic        dmemREN, dmemWEN, mem_stall, link_valid;
  logic [31:0] dmemaddr, dmemstore, memload_out;

  int n_checks = 0;
  int n_pass   = 0;

  int          cnt_ren, cnt_wen, cnt_stall;
  logic [31:0] wen_addr, wen_data, res;

  mem_access_unit #(.WORD_W(32)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .dmemREN_in   (dmemREN_in),
    .dmemWEN_in   (dmemWEN_in),
    .datomic_in   (datomic_in),
    .dmemaddr_in  (dmemaddr_in),
    .dmemstore_in (dmemstore_in),
    .halt_in      (halt_in),
    .flush        (flush),
    .pipe_advance (pipe_advance),
    .dhit         (dhit),
    .dmemload     (dmemload),
    .snoop_inv    (snoop_inv),
    .snoop_addr   (snoop_addr),
    .dmemREN      (dmemREN),
    .dmemWEN      (dmemWEN),
    .dmemaddr     (dmemaddr),
    .dmemstore    (dmemstore),
    .mem_stall    (mem_stall),
    .memload_out  (memload_out),
    .link_valid   (link_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    dmemREN_in = 0; dmemWEN_in = 0; datomic_in = 0; dmemaddr_in = 0; dmemstore_in = 0;
    halt_in = 0; flush = 0; pipe_advance = 0; dhit = 0; dmemload = 0;
    snoop_inv = 0; snoop_addr = 0;
  endtask

  // Runs one transaction from IDLE to IDLE; dhit arrives on ACCESS cycle miss+1.
  task automatic do_access(input logic ren, input logic wen, input logic atm,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int miss, input int hold,
                           input bit snp);
    int  acc;
    bit  done;
    acc = 0; done = 0;
    cnt_ren = 0; cnt_wen = 0; cnt_stall = 0; wen_addr = 0; wen_data = 0; res = 0;
    step();
    dmemREN_in = ren; dmemWEN_in = wen; datomic_in = atm;
    dmemaddr_in = addr; dmemstore_in = wdata; dmemload = rdata;
    snoop_inv = snp; snoop_addr = addr;
    for (int c = 0; c < 20 && !done; c++) begin
      #4;
      if (!mem_stall) begin
        done = 1;
        res  = memload_out;
      end else begin
        cnt_stall++;
        if (dmemREN) cnt_ren++;
        if (dmemWEN) begin
          cnt_wen++;
          wen_addr = dmemaddr;
          wen_data = dmemstore;
        end
        if (dmemREN || dmemWEN) begin
          acc++;
          dhit = (acc == miss + 1);
        end
        step();
        dhit = 0;
        snoop_inv = 0;
      end
    end
    if (!done) check_eq("done_timeout", 32'd0, 32'd1);
    for (int h = 0; h < hold; h++) begin
      step();
      #4;
      check_eq("hold_stall", {31'd0, mem_stall}, 32'd0);
      check_eq("hold_noreq", {31'd0, dmemREN | dmemWEN}, 32'd0);
      check_eq("hold_data", memload_out, res);
    end
    pipe_advance = 1;
    step();
    clear_inputs();
  endtask

  task automatic idle_event(input bit snp, input logic [31:0] sa, input bit hlt);
    step();
    snoop_inv = snp; snoop_addr = sa; halt_in = hlt;
    step();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    nRST = 0;
    #12;
    check_eq("rst_ren", {31'd0, dmemREN}, 32'd0);
    check_eq("rst_wen", {31'd0, dmemWEN}, 32'd0);
    check_eq("rst_stall", {31'd0, mem_stall}, 32'd0);
    check_eq("rst_load", memload_out, 32'd0);
    check_eq("rst_link", {31'd0, link_valid}, 32'd0);
    step();
    nRST = 1;

    // lw 0x100, two misses then hit: REN 3 cycles, stall 4 cycles
    do_access(1, 0, 0, 32'h100, 0, 32'hDEADBEEF, 2, 0, 0);
    check_eq("lw_ren_cycles", cnt_ren, 3);
    check_eq("lw_stall_cycles", cnt_stall, 4);
    check_eq("lw_no_wen", cnt_wen, 0);
    check_eq("lw_data", res, 32'hDEADBEEF);

    // ll then sc same word: succeeds, link cleared
    do_access(1, 0, 1, 32'h200, 0, 32'h11, 0, 0, 0);
    check_eq("ll_data", res, 32'h11);
    check_eq("ll_link", {31'd0, link_valid}, 32'd1);
    do_access(0, 1, 1, 32'h200, 32'h5, 0, 0, 0, 0);
    check_eq("sc_wen_cnt", cnt_wen, 1);
    check_eq("sc_wen_addr", wen_addr, 32'h200);
    check_eq("sc_wen_data", wen_data, 32'h5);
    check_eq("sc_result", res, 32'd1);
    check_eq("sc_stall", cnt_stall, 2);
    check_eq("sc_link_after", {31'd0, link_valid}, 32'd0);

    // ll, snoop on linked word, sc fails in one stall cycle
    do_access(1, 0, 1, 32'h200, 0, 32'h22, 0, 0, 0);
    idle_event(1, 32'h200, 0);
    check_eq("snoop_link", {31'd0, link_valid}, 32'd0);
    do_access(0, 1, 1, 32'h200, 32'h5, 0, 0, 0, 0);
    check_eq("scf_wen_cnt", cnt_wen, 0);
    check_eq("scf_result", res, 32'd0);
    check_eq("scf_stall", cnt_stall, 1);

    // sw to neighbouring word keeps link
    do_access(1, 0, 1, 32'h200, 0, 32'h33, 0, 0, 0);
    do_access(0, 1, 0, 32'h204, 32'h9, 0, 1, 0, 0);
    check_eq("sw204_link", {31'd0, link_valid}, 32'd1);
    do_access(0, 1, 1, 32'h200, 32'h6, 0, 0, 0, 0);
    check_eq("sc_after_sw204", res, 32'd1);

    // sw to linked word kills link
    do_access(1, 0, 1, 32'h200, 0, 32'h44, 0, 0, 0);
    do_access(0, 1, 0, 32'h200, 32'h9, 0, 0, 0, 0);
    check_eq("sw200_link", {31'd0, link_valid}, 32'd0);
    do_access(0, 1, 1, 32'h200, 32'h7, 0, 0, 0, 0);
    check_eq("sc_after_sw200", res, 32'd0);
    check_eq("sc_after_sw200_wen", cnt_wen, 0);

    // snoop in the same cycle as the sc check
    do_access(1, 0, 1, 32'h200, 0, 32'h55, 0, 0, 0);
    do_access(0, 1, 1, 32'h200, 32'h8, 0, 0, 0, 1);
    check_eq("sc_samecyc_snoop", res, 32'd0);
    check_eq("sc_samecyc_wen", cnt_wen, 0);

    // flush in IDLE suppresses request
    step();
    dmemREN_in = 1; dmemaddr_in = 32'h300; flush = 1;
    #4;
    check_eq("flush_stall", {31'd0, mem_stall}, 32'd0);
    step();
    #4;
    check_eq("flush_noreq", {31'd0, dmemREN}, 32'd0);
    check_eq("flush_stall2", {31'd0, mem_stall}, 32'd0);
    clear_inputs();

    // DONE held two cycles without pipe_advance
    do_access(1, 0, 0, 32'h300, 0, 32'h1234, 0, 2, 0);
    check_eq("hold_result", res, 32'h1234);

    // halt clears link
    do_access(1, 0, 1, 32'h200, 0, 32'h66, 0, 0, 0);
    idle_event(0, 0, 1);
    check_eq("halt_link", {31'd0, link_valid}, 32'd0);

    // illegal REN+WEN behaves as store
    do_access(1, 1, 0, 32'h180, 32'hAB, 32'hFF, 0, 0, 0);
    check_eq("both_wen", cnt_wen, 1);
    check_eq("both_ren", cnt_ren, 0);
    check_eq("both_wdata", wen_data, 32'hAB);

    // async reset mid-ACCESS
    do_access(1, 0, 1, 32'h200, 0, 32'h77, 0, 0, 0);
    step();
    dmemREN_in = 1; dmemaddr_in = 32'h400;
    step();
    #2;
    check_eq("pre_rst_ren", {31'd0, dmemREN}, 32'd1);
    nRST = 0;
    #1;
    check_eq("arst_ren", {31'd0, dmemREN}, 32'd0);
    check_eq("arst_link", {31'd0, link_valid}, 32'd0);
    check_eq("arst_load", memload_out, 32'd0);
    check_eq("arst_addr", dmemaddr, 32'd0);
    clear_inputs();
    step();
    nRST = 1;
    do_access(1, 0, 0, 32'h500, 0, 32'hCAFE, 0, 0, 0);
    check_eq("post_rst_lw", res, 32'hCAFE);
    check_eq("post_rst_stall", cnt_stall, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
